// File: rtl/seg_chase_decoder_if.sv
// Segment-line and decoded-status bundle for seg_chase_decoder.
// master: drives seg_in, observes status; slave: the decoder.
interface seg_chase_decoder_if #(
    parameter int STEP_TIMER_WIDTH = 24
);
    // seg_in[6:0] = segments a..g, seg_in[7] = decimal point
    logic [7:0]                  seg_in;
    logic [2:0]                  seq_pos;
    logic                        dir;
    logic                        locked;
    logic                        step_valid;
    logic                        dir_flip;
    logic [STEP_TIMER_WIDTH-1:0] step_period;
    logic [4:0]                  active_level;

    modport master (
        output seg_in,
        input  seq_pos,
        input  dir,
        input  locked,
        input  step_valid,
        input  dir_flip,
        input  step_period,
        input  active_level
    );

    modport slave (
        input  seg_in,
        output seq_pos,
        output dir,
        output locked,
        output step_valid,
        output dir_flip,
        output step_period,
        output active_level
    );
endinterface

// File: rtl/seg_chase_decoder.sv
// Demodulates the PWM brightness of a seven-segment chase display and
// recovers the chase position, direction and step period.
//
// Ports:
//   clk    clock
//   reset  asynchronous active-low reset
//   bus    seg_chase_decoder_if.slave
//            seg_in       segment lines a..g on [6:0], [7] (dp) ignored
//            seq_pos      recovered chase position 0..7
//            dir          1 = incrementing, 0 = decrementing
//            locked       tracking a valid sequence
//            step_valid   one-cycle pulse per accepted step
//            dir_flip     one-cycle pulse when a step reverses dir
//            step_period  cycles between the last two accepted steps
//            active_level level of the active segment, 0 if none
//
// Optional: define SEG_CHASE_DECODER_GLITCH_FILTER_EN to accept a new
// argmax result only after two consecutive windows agree.
module seg_chase_decoder #(
    parameter int PWM_WINDOW_WIDTH = 8,
    parameter int ON_THRESHOLD     = 24,
    parameter int STEP_TIMER_WIDTH = 24,
    parameter bit COMMON_ANODE     = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    seg_chase_decoder_if.slave bus
);

    localparam int W  = PWM_WINDOW_WIDTH;
    localparam int AW = W + 1;
    localparam int SH = W - 5;
    localparam int TW = STEP_TIMER_WIDTH;

    typedef enum logic [1:0] {
        SEARCH,
        ACQUIRE,
        LOCKED
    } state_t;

    // ---------------- input path ----------------
    logic [6:0] sync1_q;
    logic [6:0] sync2_q;
    logic [6:0] seg_on;
    logic       unused_dp;

    assign unused_dp = bus.seg_in[7];
    assign seg_on    = COMMON_ANODE ? ~sync2_q : sync2_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= bus.seg_in[6:0];
            sync2_q <= sync1_q;
        end
    end

    // ---------------- duty measurement ----------------
    logic [W-1:0]  wc_q;
    logic          win_end;
    logic          lvl_vld_q;
    logic [AW-1:0] acc_q [7];
    logic [AW-1:0] acc_nx [7];
    logic [4:0]    lvl_q [7];

    assign win_end = &wc_q;

    function automatic logic [4:0] sat_lvl(input logic [AW-1:0] a);
        logic [AW-1:0] s;
        s = a >> SH;
        if (s > AW'(31)) return 5'd31;
        return s[4:0];
    endfunction

    // The window-end cycle itself is counted before latching.
    always_comb begin
        for (int i = 0; i < 7; i++) begin
            acc_nx[i] = acc_q[i] + AW'(seg_on[i]);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wc_q      <= '0;
            lvl_vld_q <= 1'b0;
            for (int i = 0; i < 7; i++) begin
                acc_q[i] <= '0;
                lvl_q[i] <= '0;
            end
        end else begin
            wc_q      <= wc_q + 1'b1;
            lvl_vld_q <= win_end;
            for (int i = 0; i < 7; i++) begin
                if (win_end) begin
                    acc_q[i] <= '0;
                    lvl_q[i] <= sat_lvl(acc_nx[i]);
                end else begin
                    acc_q[i] <= acc_nx[i];
                end
            end
        end
    end

    // ---------------- argmax ----------------
    logic       win_vld;
    logic [2:0] win_seg;
    logic [4:0] win_lvl;
    logic       accept;

    // Strict '>' keeps the lowest index on ties.
    always_comb begin
        win_vld = 1'b0;
        win_seg = '0;
        win_lvl = '0;
        for (int i = 0; i < 7; i++) begin
            if (int'(lvl_q[i]) >= ON_THRESHOLD &&
                (!win_vld || lvl_q[i] > win_lvl)) begin
                win_vld = 1'b1;
                win_seg = 3'(i);
                win_lvl = lvl_q[i];
            end
        end
    end

`ifdef SEG_CHASE_DECODER_GLITCH_FILTER_EN
    logic       prv_vld_q;
    logic [2:0] prv_seg_q;

    assign accept = (win_vld == prv_vld_q) && (win_seg == prv_seg_q);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prv_vld_q <= 1'b0;
            prv_seg_q <= '0;
        end else if (lvl_vld_q) begin
            prv_vld_q <= win_vld;
            prv_seg_q <= win_seg;
        end
    end
`else
    assign accept = 1'b1;
`endif

    logic       arg_vld_q;
    logic       act_vld_q;
    logic [2:0] act_seg_q;
    logic [4:0] act_lvl_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            arg_vld_q <= 1'b0;
            act_vld_q <= 1'b0;
            act_seg_q <= '0;
            act_lvl_q <= '0;
        end else begin
            arg_vld_q <= lvl_vld_q && accept;
            if (lvl_vld_q && accept) begin
                act_vld_q <= win_vld;
                act_seg_q <= win_seg;
                act_lvl_q <= win_lvl;
            end
        end
    end

    // ---------------- pair lookup ----------------
    // Returns {hit, pos} for a forward (prev, new) segment pair.
    function automatic logic [3:0] fwd_pos(
        input logic [2:0] p,
        input logic [2:0] n
    );
        unique case ({p, n})
            {3'd5, 3'd0}: return {1'b1, 3'd0};
            {3'd0, 3'd1}: return {1'b1, 3'd1};
            {3'd1, 3'd6}: return {1'b1, 3'd2};
            {3'd6, 3'd4}: return {1'b1, 3'd3};
            {3'd4, 3'd3}: return {1'b1, 3'd4};
            {3'd3, 3'd2}: return {1'b1, 3'd5};
            {3'd2, 3'd6}: return {1'b1, 3'd6};
            {3'd6, 3'd5}: return {1'b1, 3'd7};
            default:      return 4'b0;
        endcase
    endfunction

    state_t     state_q;
    state_t     state_d;
    logic [2:0] ref_q;
    logic [2:0] ref_d;
    logic [3:0] f_hit;
    logic [3:0] r_hit;
    logic       pr_hit;
    logic       pr_dir;
    logic [2:0] pr_pos;

    // Forward and reverse sets are disjoint, so at most one hits.
    assign f_hit  = fwd_pos(ref_q, act_seg_q);
    assign r_hit  = fwd_pos(act_seg_q, ref_q);
    assign pr_hit = f_hit[3] | r_hit[3];
    assign pr_dir = f_hit[3];
    assign pr_pos = f_hit[3] ? f_hit[2:0] : r_hit[2:0] - 3'd1;

    // ---------------- tracking FSM ----------------
    logic [2:0]    pos_q;
    logic [2:0]    pos_d;
    logic          dir_q;
    logic          dir_d;
    logic          lock_q;
    logic          lock_d;
    logic          sv_q;
    logic          sv_d;
    logic          flip_q;
    logic          flip_d;
    logic [TW-1:0] tmr_q;
    logic [TW-1:0] tmr_d;
    logic [TW-1:0] per_q;
    logic [TW-1:0] per_d;
    logic          new_seg;

    assign new_seg = arg_vld_q && act_vld_q && (act_seg_q != ref_q);

    always_comb begin
        state_d = state_q;
        ref_d   = ref_q;
        pos_d   = pos_q;
        dir_d   = dir_q;
        lock_d  = lock_q;
        sv_d    = 1'b0;
        flip_d  = 1'b0;
        per_d   = per_q;
        tmr_d   = tmr_q + 1'b1;
        if (&tmr_q) begin
            state_d = SEARCH;
            lock_d  = 1'b0;
            tmr_d   = '0;
        end else begin
            unique case (state_q)
                SEARCH: begin
                    if (arg_vld_q && act_vld_q) begin
                        ref_d   = act_seg_q;
                        state_d = ACQUIRE;
                    end
                end
                ACQUIRE: begin
                    if (new_seg) begin
                        ref_d = act_seg_q;
                        if (pr_hit) begin
                            pos_d   = pr_pos;
                            dir_d   = pr_dir;
                            lock_d  = 1'b1;
                            sv_d    = 1'b1;
                            tmr_d   = '0;
                            state_d = LOCKED;
                        end
                    end
                end
                LOCKED: begin
                    if (new_seg) begin
                        ref_d = act_seg_q;
                        if (pr_hit) begin
                            pos_d  = pr_pos;
                            dir_d  = pr_dir;
                            sv_d   = 1'b1;
                            flip_d = pr_dir != dir_q;
                            // +1: the restart cycle itself is a step cycle
                            per_d  = tmr_q + 1'b1;
                            tmr_d  = '0;
                        end else begin
                            lock_d  = 1'b0;
                            state_d = ACQUIRE;
                        end
                    end
                end
                default: state_d = SEARCH;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= SEARCH;
            ref_q   <= '0;
            pos_q   <= '0;
            dir_q   <= 1'b0;
            lock_q  <= 1'b0;
            sv_q    <= 1'b0;
            flip_q  <= 1'b0;
            tmr_q   <= '0;
            per_q   <= '0;
        end else begin
            state_q <= state_d;
            ref_q   <= ref_d;
            pos_q   <= pos_d;
            dir_q   <= dir_d;
            lock_q  <= lock_d;
            sv_q    <= sv_d;
            flip_q  <= flip_d;
            tmr_q   <= tmr_d;
            per_q   <= per_d;
        end
    end

    assign bus.seq_pos      = pos_q;
    assign bus.dir          = dir_q;
    assign bus.locked       = lock_q;
    assign bus.step_valid   = sv_q;
    assign bus.dir_flip     = flip_q;
    assign bus.step_period  = per_q;
    assign bus.active_level = act_lvl_q;

endmodule

// File: tb/tb_seg_chase_decoder.sv
// Directed bench for seg_chase_decoder (active-low segment lines).
// Uses a 14-bit step timer so the timeout case stays short.
module tb_seg_chase_decoder;

    localparam int TW = 14;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_chk = 0;
    int   n_pass = 0;
    int   n_step = 0;
    int   n_flip = 0;

    seg_chase_decoder_if #(.STEP_TIMER_WIDTH(TW)) bus ();

    seg_chase_decoder #(
        .PWM_WINDOW_WIDTH(8),
        .ON_THRESHOLD(24),
        .STEP_TIMER_WIDTH(TW),
        .COMMON_ANODE(1'b1)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.step_valid) n_step++;
        if (bus.dir_flip) n_flip++;
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, want %0d", tag, got, exp);
    endtask

    // Advance n edges, land 1 time unit after the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        bus.seg_in = 8'hFF;
        tick(3);
        reset = 1'b1;
    endtask

    // Fully light one segment (active low).
    task automatic show(input int seg, input int n);
        bus.seg_in = ~(8'h01 << seg);
        tick(n);
    endtask

    int segs1 [9] = '{0, 1, 6, 4, 3, 2, 6, 5, 0};
    int pos1  [9] = '{0, 1, 2, 3, 4, 5, 6, 7, 0};
    int segs2 [7] = '{1, 6, 4, 3, 4, 6, 1};
    int pos2  [7] = '{1, 2, 3, 4, 3, 2, 1};
    int dir2  [7] = '{1, 1, 1, 1, 0, 0, 0};
    int s0;
    int f0;

    initial begin
        bus.seg_in = 8'hFF;
        tick(2);
        chk("rst_locked", int'(bus.locked), 0);
        chk("rst_pos", int'(bus.seq_pos), 0);
        chk("rst_level", int'(bus.active_level), 0);
        do_reset();

        // forward chase
        s0 = n_step;
        f0 = n_flip;
        for (int i = 0; i < 9; i++) begin
            show(segs1[i], 1024);
            if (i == 0) begin
                chk("fwd_unlocked", int'(bus.locked), 0);
            end else begin
                chk($sformatf("fwd_pos%0d", i), int'(bus.seq_pos), pos1[i]);
                chk($sformatf("fwd_dir%0d", i), int'(bus.dir), 1);
                chk($sformatf("fwd_lock%0d", i), int'(bus.locked), 1);
            end
        end
        chk("fwd_period", int'(bus.step_period), 1024);
        chk("fwd_steps", n_step - s0, 8);
        chk("fwd_flips", n_flip - f0, 0);
        chk("fwd_level", int'(bus.active_level), 31);

        // continue forward, then reverse
        for (int i = 0; i < 7; i++) begin
            show(segs2[i], 1024);
            chk($sformatf("rev_pos%0d", i), int'(bus.seq_pos), pos2[i]);
            chk($sformatf("rev_dir%0d", i), int'(bus.dir), dir2[i]);
        end
        chk("rev_flips", n_flip - f0, 1);
        chk("rev_steps", n_step - s0, 15);

        // seg-6 ambiguity
        do_reset();
        show(2, 512);
        show(6, 512);
        chk("amb26_pos", int'(bus.seq_pos), 6);
        chk("amb26_dir", int'(bus.dir), 1);
        do_reset();
        show(1, 512);
        show(6, 512);
        chk("amb16_pos", int'(bus.seq_pos), 2);
        chk("amb16_dir", int'(bus.dir), 1);
        do_reset();
        show(5, 512);
        show(6, 512);
        chk("amb56_pos", int'(bus.seq_pos), 6);
        chk("amb56_dir", int'(bus.dir), 0);
        chk("amb56_lock", int'(bus.locked), 1);

        // PWM levels
        do_reset();
        for (int i = 0; i < 600; i++) begin
            bus.seg_in = 8'hFF;
            bus.seg_in[0] = 1'(i % 2);
            tick(1);
        end
        chk("pwm50_level", int'(bus.active_level), 0);
        chk("pwm50_lock", int'(bus.locked), 0);
        for (int i = 0; i < 600; i++) begin
            bus.seg_in = 8'hFF;
            bus.seg_in[0] = 1'b0;
            bus.seg_in[1] = (i % 4) != 0;
            tick(1);
        end
        chk("pwm100_level", int'(bus.active_level), 31);

        // tie goes to lowest index, dp ignored: 0+1 tie then 1 alone
        do_reset();
        bus.seg_in = 8'h7C;
        tick(512);
        show(1, 512);
        chk("tie_lock", int'(bus.locked), 1);
        chk("tie_pos", int'(bus.seq_pos), 1);

        // invalid jump while locked
        do_reset();
        show(0, 512);
        show(1, 512);
        chk("jmp_pre", int'(bus.locked), 1);
        show(3, 512);
        chk("jmp_unlock", int'(bus.locked), 0);
        chk("jmp_hold", int'(bus.seq_pos), 1);
        show(2, 512);
        chk("jmp_relock", int'(bus.locked), 1);
        chk("jmp_pos", int'(bus.seq_pos), 5);

        // timeout
        do_reset();
        show(0, 512);
        show(1, 512);
        show(6, 512);
        chk("to_period", int'(bus.step_period), 512);
        chk("to_pre", int'(bus.locked), 1);
        tick(17000);
        chk("to_unlock", int'(bus.locked), 0);
        chk("to_keep", int'(bus.step_period), 512);
        show(4, 512);
        chk("to_relock", int'(bus.locked), 1);
        chk("to_pos", int'(bus.seq_pos), 3);

        // mid-window reset
        tick(100);
        reset = 1'b0;
        bus.seg_in = ~8'h01;
        #1;
        chk("mrst_locked", int'(bus.locked), 0);
        chk("mrst_pos", int'(bus.seq_pos), 0);
        chk("mrst_period", int'(bus.step_period), 0);
        chk("mrst_level", int'(bus.active_level), 0);
        tick(2);
        reset = 1'b1;
        tick(256);
        chk("mrst_win_early", int'(bus.active_level), 0);
        tick(1);
        chk("mrst_win_first", int'(bus.active_level), 31);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/seg_chase_decoder.md
Name: seg_chase_decoder

Overview:
- Receive-side companion to the fading seven-segment chase driver.
- Samples the eight segment lines and demodulates each segment's PWM duty into a 5-bit brightness level.
- Identifies the fully lit segment and recovers the driver's 3-bit chase position, its direction and its step period.
- Used on-chip as a loopback monitor, and on a second tile to read a neighbouring design's display.

Parameters:
PWM_WINDOW_WIDTH, 8, log2 of the duty measurement window in clk cycles (window = 256 cycles)
ON_THRESHOLD, 24, minimum 5-bit level for a segment to count as lit
STEP_TIMER_WIDTH, 24, width of the step-period timer
COMMON_ANODE, 1, 1 = segment inputs are active-low and are inverted internally

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-low reset
seg_in  input  8  segment lines a..g on bits 0..6; bit 7 (decimal point) ignored
seq_pos  output  3  recovered chase position 0..7
dir  output  1  1 = position incrementing, 0 = decrementing
locked  output  1  decoder tracking a valid sequence
step_valid  output  1  one-cycle pulse per accepted step
dir_flip  output  1  one-cycle pulse when an accepted step reverses dir
step_period  output  STEP_TIMER_WIDTH  cycles between the last two accepted steps
active_level  output  5  level of the current active segment, 0 if none

Behaviour:
- Reset (reset low, asynchronous): all outputs 0, FSM in SEARCH, accumulators, timers and synchronizers cleared.
- Input path: 2-FF synchronizer on seg_in[6:0], then inversion when COMMON_ANODE=1.
- Duty measurement:
  - Window counter wc, PWM_WINDOW_WIDTH bits; one (PWM_WINDOW_WIDTH+1)-bit accumulator per segment, incremented on cycles where the segment is on.
  - At wc = all-ones (window end), latch level[i] = min(acc[i] >> (PWM_WINDOW_WIDTH-5), 31), counting the current cycle, and clear the accumulators.
- Argmax (registered 1 cycle after window end):
  - Active segment = highest level[i] >= ON_THRESHOLD; ties go to the lowest index. None qualifying = no active segment.
  - active_level updates on the same cycle.
- Position map pos->seg: 0->0, 1->1, 2->6, 3->4, 4->3, 5->2, 6->6, 7->5.
  - Forward pair table (prev,new)->pos: (5,0)->0, (0,1)->1, (1,6)->2, (6,4)->3, (4,3)->4, (3,2)->5, (2,6)->6, (6,5)->7.
  - Reverse pairs are the same pairs swapped; they resolve to dir=0 with pos = table entry of the swapped pair minus 1, mod 8.
  - The forward and reverse sets are disjoint. Segment 6 is therefore always resolved by its neighbour.
- Step event: the active segment changes to a different, non-none segment. A change to none is not a step; the reference segment is kept.
- FSM, evaluated the cycle after argmax:
  - SEARCH: first active segment becomes the reference -> ACQUIRE.
  - ACQUIRE: step whose pair is in the table -> set seq_pos and dir, locked=1, step_valid pulse, restart timer -> LOCKED. Pair not found -> new segment becomes the reference, stay in ACQUIRE.
  - LOCKED, pair found: update seq_pos and dir, pulse step_valid, and load step_period with the timer value.
  - LOCKED, pair found with dir differing from the current dir: also pulse dir_flip.
  - LOCKED, pair not found: locked=0 -> ACQUIRE with the new reference. seq_pos, dir and step_period hold their values.
- Latency: step_valid is high exactly 2 cycles after the window end whose levels first show the new segment.
- Step timer: counts every cycle, saturates at all-ones. Saturation in any state -> SEARCH, locked=0, timer cleared. step_period retains its last value.
- Asserting reset mid-window discards the partial window. The first window after release is a full window.

Optional Feature:
SEG_CHASE_DECODER_GLITCH_FILTER_EN
- Defined: a new argmax segment is accepted only after 2 consecutive windows show the same segment. step_valid latency becomes 2 cycles after the second such window end.
- Undefined: the argmax is accepted on the first window, as above.

Test Plan:
1. Forward chase: drive segs 0,1,6,4,3,2,6,5 fully on, 4 windows (1024 cycles) each. -> locked=1 on the 0->1 step; seq_pos 1,2,3,4,5,6,7,0; dir=1; step_period=1024; no dir_flip.
2. Reverse after forward: switch order mid-run, 3->4->6->1. -> step at seg 4 gives seq_pos=3, dir=0, one dir_flip pulse; then seq_pos 2, 1.
3. Seg-6 ambiguity: from reset show 2 then 6 -> seq_pos=6. From reset show 1 then 6 -> seq_pos=2. From reset show 5 then 6 -> seq_pos=6, dir=0.
4. PWM levels: seg0 at 50% duty -> level 16, no active segment, active_level=0. Seg0 at 100% with seg1 at 25% fading -> active segment 0, active_level=31.
5. Invalid jump while LOCKED (0->3) -> locked=0, state ACQUIRE. A following 3->2 step -> locked=1, seq_pos=5.
6. Timeout and reset: hold seg 1 for 2^24 cycles -> locked=0, SEARCH. Pulse reset low mid-window -> all outputs 0 at once; after release, the first level latch comes 256 cycles later.
